// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, one fetch per cycle into a circular
// {pc, instr} prefetch queue, head presented to decode over valid/ready.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic [31:0]              imem_addr_o,
    input  logic [31:0]              imem_instr_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     id_valid_o,
    input  logic                     id_ready_i,
    output logic [31:0]              id_instr_o,
    output logic [31:0]              id_pc_o,
    output logic [$clog2(DEPTH):0]   queue_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   r_pc;
    logic [31:0]   r_q_pc    [DEPTH];
    logic [31:0]   r_q_instr [DEPTH];
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_wptr;
    logic [CW-1:0] r_cnt;

    logic w_pop;
    logic w_full;
    logic w_push;

    assign w_pop  = id_valid_o & id_ready_i;
    assign w_full = (r_cnt == CW'(DEPTH));
    assign w_push = ~redirect_i & (~w_full | w_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc   <= RESET_PC;
            r_rptr <= '0;
            r_wptr <= '0;
            r_cnt  <= '0;
        end else if (redirect_i) begin
            r_pc   <= {redirect_pc_i[31:2], 2'b00};
            r_rptr <= '0;
            r_wptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_pc   <= r_pc + 32'd4;
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // NOTE: the queue storage is reset so the head outputs read 0, not X,
    // while the queue is empty after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_pc[i]    <= '0;
                r_q_instr[i] <= '0;
            end
        end else if (w_push) begin
            r_q_pc[r_wptr]    <= r_pc;
            r_q_instr[r_wptr] <= imem_instr_i;
        end
    end

    assign imem_addr_o = r_pc;
    assign id_valid_o  = (r_cnt != '0);
    assign id_pc_o     = r_q_pc[r_rptr];
    assign id_instr_o  = r_q_instr[r_rptr];
    assign queue_cnt_o = r_cnt;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; memory word at byte address a is
// 32'h1000_0000 + (a >> 2), modelled combinationally.
module tb_instr_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [1:0]  queue_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    assign imem_instr_i = 32'h1000_0000 + (imem_addr_o >> 2);

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .imem_addr_o  (imem_addr_o),
        .imem_instr_i (imem_instr_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .id_valid_o   (id_valid_o),
        .id_ready_i   (id_ready_i),
        .id_instr_o   (id_instr_o),
        .id_pc_o      (id_pc_o),
        .queue_cnt_o  (queue_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, " valid"}, {31'd0, id_valid_o}, 32'd1);
        check({tag, " pc"},    id_pc_o, pc);
        check({tag, " instr"}, id_instr_o, 32'h1000_0000 + (pc >> 2));
    endtask

    initial begin
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        id_ready_i    = 1'b0;

        // Reset state
        #2;
        check("rst valid", {31'd0, id_valid_o}, 32'd0);
        check("rst addr",  imem_addr_o, 32'h0);
        check("rst cnt",   {30'd0, queue_cnt_o}, 32'd0);
        check("rst instr", id_instr_o, 32'h0);
        check("rst pc",    id_pc_o, 32'h0);

        // Free-run: one instruction per cycle, count steady at 1
        @(negedge clk_i);
        rst_i      = 1'b0;
        id_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            check_head("run", 32'(4 * k));
            check("run cnt", {30'd0, queue_cnt_o}, 32'd1);
        end

        // Backpressure after a fresh reset
        rst_i      = 1'b1;
        id_ready_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check("bp cnt",  {30'd0, queue_cnt_o}, (k == 0) ? 32'd1 : 32'd2);
            check("bp addr", imem_addr_o, (k == 0) ? 32'd4 : 32'd8);
            check_head("bp head", 32'h0);
        end

        // Release: full with simultaneous push/pop, then in-order delivery
        id_ready_i = 1'b1;
        @(negedge clk_i);
        check("full cnt",  {30'd0, queue_cnt_o}, 32'd2);
        check("full addr", imem_addr_o, 32'd12);
        check_head("rel", 32'd4);
        @(negedge clk_i);
        check_head("rel", 32'd8);
        @(negedge clk_i);
        check_head("rel", 32'd12);
        check("rel cnt",  {30'd0, queue_cnt_o}, 32'd2);
        check("rel addr", imem_addr_o, 32'd20);

        // Redirect while full, misaligned target
        id_ready_i    = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0043;
        @(negedge clk_i);
        redirect_i = 1'b0;
        check("redir cnt",   {30'd0, queue_cnt_o}, 32'd0);
        check("redir valid", {31'd0, id_valid_o}, 32'd0);
        check("redir addr",  imem_addr_o, 32'h40);
        @(negedge clk_i);
        check_head("redir tgt", 32'h40);

        // PC wrap with ready high
        id_ready_i    = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        @(negedge clk_i);
        redirect_i = 1'b0;
        check("wrap addr", imem_addr_o, 32'hFFFF_FFF8);
        @(negedge clk_i);
        check_head("wrap", 32'hFFFF_FFF8);
        check("wrap instr0", id_instr_o, 32'h4FFF_FFFE);
        @(negedge clk_i);
        check_head("wrap", 32'hFFFF_FFFC);
        @(negedge clk_i);
        check_head("wrap", 32'h0);
        check("wrap addr2", imem_addr_o, 32'h4);

        // Asynchronous reset between edges with the queue full
        id_ready_i = 1'b0;
        @(negedge clk_i);
        check("pre-rst cnt", {30'd0, queue_cnt_o}, 32'd2);
        #2 rst_i = 1'b1;
        #1;
        check("arst valid", {31'd0, id_valid_o}, 32'd0);
        check("arst addr",  imem_addr_o, 32'h0);
        check("arst cnt",   {30'd0, queue_cnt_o}, 32'd0);
        #1 rst_i = 1'b0;
        id_ready_i = 1'b1;
        @(negedge clk_i);
        check_head("resume", 32'h0);
        @(negedge clk_i);
        check_head("resume", 32'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
